// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with saturating direction counters and prediction statistics
module btb_predictor #(
   parameter int ADDR_W  = 16,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 2,
   parameter int STAT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [STAT_W-1:0] correct_cnt,
   output logic [STAT_W-1:0] mispred_cnt
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
   logic              valid_q [ENTRIES];
   logic [TAG_W-1:0]  tag_q   [ENTRIES];
   logic [ADDR_W-1:0] tgt_q   [ENTRIES];
   logic [CNT_W-1:0]  cnt_q   [ENTRIES];
   logic [IDX_W-1:0]  l_idx, u_idx;
   logic [TAG_W-1:0]  l_tag, u_tag;
   logic              u_hit;
   assign l_idx = lookup_pc[IDX_W-1:0];
   assign l_tag = lookup_pc[ADDR_W-1:IDX_W];
   assign u_idx = upd_pc[IDX_W-1:0];
   assign u_tag = upd_pc[ADDR_W-1:IDX_W];
   assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
   always_comb begin
      pred_hit    = valid_q[l_idx] & (tag_q[l_idx] == l_tag);
      pred_taken  = pred_hit & cnt_q[l_idx][CNT_W-1];
      pred_target = pred_taken ? tgt_q[l_idx] : lookup_pc + ADDR_W'(1);
      mispredict  = upd_en & ((upd_taken != upd_pred_taken) | (upd_taken & (upd_target != upd_pred_target)));
      redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(1);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            cnt_q[i]   <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (upd_en) begin
         if (u_hit && upd_taken) begin
            cnt_q[u_idx] <= (cnt_q[u_idx] == CNT_MAX) ? CNT_MAX : cnt_q[u_idx] + CNT_W'(1);
            tgt_q[u_idx] <= upd_target;
         end else if (u_hit) begin
            cnt_q[u_idx] <= (cnt_q[u_idx] == '0) ? '0 : cnt_q[u_idx] - CNT_W'(1);
         end else if (upd_taken) begin
            valid_q[u_idx] <= 1'b1;
            tag_q[u_idx]   <= u_tag;
            tgt_q[u_idx]   <= upd_target;
            cnt_q[u_idx]   <= CNT_WEAK;
         end
      end
   end
   // statistics count every resolved update, flushed or not, and stick at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         correct_cnt <= '0;
         mispred_cnt <= '0;
      end else if (upd_en) begin
         if (!mispredict && correct_cnt != '1) correct_cnt <= correct_cnt + STAT_W'(1);
         if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + STAT_W'(1);
      end
   end
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed checks of lookup, counter walk, aliasing, flush, async reset and saturation
module tb_btb_predictor;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] lookup_pc = '0;
   logic        pred_hit, pred_taken;
   logic [15:0] pred_target;
   logic        upd_en = 1'b0;
   logic [15:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [15:0] upd_target = '0;
   logic        upd_pred_taken = 1'b0;
   logic [15:0] upd_pred_target = '0;
   logic        mispredict;
   logic [15:0] redirect_pc, correct_cnt, mispred_cnt;
   int n_vec = 0;
   int n_err = 0;
   btb_predictor #(.ADDR_W(16), .ENTRIES(16), .CNT_W(2), .STAT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush), .lookup_pc(lookup_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .correct_cnt(correct_cnt), .mispred_cnt(mispred_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic look(input string tag, input logic [15:0] pc, input logic hit, input logic tk, input logic [15:0] tgt);
      lookup_pc = pc;
      #1;
      chk({tag, "_hit"}, 32'(pred_hit), 32'(hit));
      chk({tag, "_taken"}, 32'(pred_taken), 32'(tk));
      chk({tag, "_target"}, 32'(pred_target), 32'(tgt));
   endtask
   task automatic upd(input string tag, input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                      input logic ptk, input logic [15:0] ptgt, input logic exp_mp, input logic [15:0] exp_rd);
      upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
      upd_pred_taken = ptk; upd_pred_target = ptgt;
      #1;
      chk({tag, "_mispredict"}, 32'(mispredict), 32'(exp_mp));
      if (exp_mp) chk({tag, "_redirect"}, 32'(redirect_pc), 32'(exp_rd));
      tick();
      upd_en = 1'b0;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end
   initial begin
      #23 rst = 1'b1;
      tick();
      look("t1", 16'h0010, 0, 0, 16'h0011);
      chk("t1_correct_cnt", 32'(correct_cnt), 0);
      chk("t1_mispred_cnt", 32'(mispred_cnt), 0);
      upd("t2", 16'h0023, 1, 16'h0040, 0, 16'h0000, 1, 16'h0040);
      look("t2", 16'h0023, 1, 1, 16'h0040);
      chk("t2_mispred_cnt", 32'(mispred_cnt), 1);
      upd("t3_tk1", 16'h0023, 1, 16'h0040, 1, 16'h0040, 0, 16'h0000);
      upd("t3_tk2", 16'h0023, 1, 16'h0040, 1, 16'h0040, 0, 16'h0000);
      chk("t3_correct_cnt", 32'(correct_cnt), 2);
      upd("t3_nt1", 16'h0023, 0, 16'h0000, 1, 16'h0040, 1, 16'h0024);
      look("t3_cnt10", 16'h0023, 1, 1, 16'h0040);
      upd("t3_nt2", 16'h0023, 0, 16'h0000, 1, 16'h0040, 1, 16'h0024);
      look("t3_cnt01", 16'h0023, 1, 0, 16'h0024);
      upd("t3_nt3", 16'h0023, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      upd("t3_nt4", 16'h0023, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      look("t3_cnt00", 16'h0023, 1, 0, 16'h0024);
      upd("t3_tk3", 16'h0023, 1, 16'h0040, 0, 16'h0000, 1, 16'h0040);
      look("t3_cnt01b", 16'h0023, 1, 0, 16'h0024);
      upd("t4", 16'h0033, 1, 16'h0050, 0, 16'h0000, 1, 16'h0050);
      look("t4_new", 16'h0033, 1, 1, 16'h0050);
      look("t4_old", 16'h0023, 0, 0, 16'h0024);
      chk("t4_mispred_cnt", 32'(mispred_cnt), 5);
      flush = 1'b1;
      upd("t5", 16'h0045, 1, 16'h0060, 0, 16'h0000, 1, 16'h0060);
      flush = 1'b0;
      look("t5_a", 16'h0033, 0, 0, 16'h0034);
      look("t5_b", 16'h0045, 0, 0, 16'h0046);
      chk("t5_mispred_cnt", 32'(mispred_cnt), 6);
      chk("t5_correct_cnt", 32'(correct_cnt), 4);
      upd("t6_alloc", 16'h0007, 1, 16'h0099, 0, 16'h0000, 1, 16'h0099);
      look("t6_pre", 16'h0007, 1, 1, 16'h0099);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_hit", 32'(pred_hit), 0);
      chk("t6_rst_correct", 32'(correct_cnt), 0);
      chk("t6_rst_mispred", 32'(mispred_cnt), 0);
      tick();
      rst = 1'b1;
      tick();
      look("t6_post", 16'h0007, 0, 0, 16'h0008);
      look("x_wrap", 16'hFFFF, 0, 0, 16'h0000);
      upd("x_redir_wrap", 16'hFFFF, 0, 16'h0000, 1, 16'h1234, 1, 16'h0000);
      upd_en = 1'b1; upd_pc = 16'h0100; upd_taken = 1'b0; upd_pred_taken = 1'b0;
      repeat (65534) tick();
      chk("x_cnt_fffe", 32'(correct_cnt), 32'h0000FFFE);
      tick();
      chk("x_cnt_ffff", 32'(correct_cnt), 32'h0000FFFF);
      repeat (3) tick();
      chk("x_cnt_hold", 32'(correct_cnt), 32'h0000FFFF);
      chk("x_mispred_keep", 32'(mispred_cnt), 1);
      upd_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
